cpu_trace_capture: RTL



---
 rtl/cpu_trace_pkg.sv | 32 +++
 rtl/trace_ring_buf.sv | 76 +++++++
 rtl/cpu_trace_capture.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared types and constants for the CPU trace recorder.
//   state_t       - capture FSM states
//   KIND_*        - event kind codes stored in each trace entry
//   CYC_W         - width of the per-entry cycle stamp
//   trace_entry_t - packed entry layout at the default widths (PC_W=6, DATA_W=32);
//                   field order matches the flat rd_data vector of cpu_trace_capture.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_POSTCAP,
    S_DONE
  } state_t;

  localparam logic [1:0] KIND_REG  = 2'b01;
  localparam logic [1:0] KIND_MEM  = 2'b10;
  localparam logic [1:0] KIND_BOTH = 2'b11;

  localparam int unsigned CYC_W      = 16;
  localparam int unsigned DEF_PC_W   = 6;
  localparam int unsigned DEF_DATA_W = 32;

  typedef struct packed {
    logic [CYC_W-1:0]      cycle;
    logic [DEF_PC_W-1:0]   pc;
    logic [1:0]            kind;
    logic [DEF_DATA_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/trace_ring_buf.sv
// trace_ring_buf: circular entry store with one write port and one registered read port.
//   i_clk/i_rst     clock, synchronous active-high reset
//   i_clr           empty the buffer; a same-cycle i_wr lands in slot 0
//   i_wr/i_wdata    append one entry; when full the oldest entry is overwritten
//   i_rd            pop the oldest entry (ignored when empty)
//   o_rd_valid      o_rd_data holds the popped entry this cycle
//   o_count/o_full  occupancy (saturates at DEPTH) and full flag
module trace_ring_buf #(
  parameter int unsigned  DEPTH = 16,
  parameter int unsigned  WIDTH = 88,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic             o_rd_valid,
  output logic [WIDTH-1:0] o_rd_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_rd_valid;
  logic [WIDTH-1:0] r_rd_data;
  logic             w_full;
  logic             w_rd_ok;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_rd_ok = i_rd && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (i_wr) r_mem[i_clr ? '0 : r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (i_clr) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= i_wr ? PTR_W'(1) : '0;
      r_count    <= i_wr ? CNT_W'(1) : '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_ok;
      // Reads and writes never coincide: the owner only reads once capture is frozen.
      if (w_rd_ok) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_count   <= r_count - 1'b1;
      end else if (i_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        // Full: drop the oldest entry so readout stays oldest-first.
        if (w_full) r_rd_ptr <= r_rd_ptr + 1'b1;
        else        r_count  <= r_count + 1'b1;
      end
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_count    = r_count;
  assign o_full     = w_full;

endmodule

// File: rtl/cpu_trace_capture.sv
// cpu_trace_capture: records register-file / data-memory write events into a ring buffer
// with a PC-match trigger, post-trigger window, oldest-first readout and timeout halt.
//   clk, rst              clock, synchronous active-high reset
//   arm                   clear buffer and start capture (same-cycle event becomes entry 0)
//   trig_pc, pc           trigger PC and current core PC
//   reg_we/addr/wdata     register-file write event
//   mem_we/addr/wdata     data-memory write event
//   rd_req                pop one entry per cycle (DONE only)
//   rd_valid, rd_data     {cycle[15:0], pc, kind[1:0], addr, data}, one cycle after rd_req
//   count                 valid entries held
//   triggered, done, halt status
// Build option: define CPU_TRACE_MEMWR_EN to record memory writes; otherwise mem_*
// inputs are ignored and only register writes (kind 01) are captured.
module cpu_trace_capture
  import cpu_trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned PC_W    = 6,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned POST    = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               arm,
  input  logic [PC_W-1:0]                    trig_pc,
  input  logic [PC_W-1:0]                    pc,
  input  logic                               reg_we,
  input  logic [REG_W-1:0]                   reg_addr,
  input  logic [DATA_W-1:0]                  reg_wdata,
  input  logic                               mem_we,
  input  logic [DATA_W-1:0]                  mem_addr,
  input  logic [DATA_W-1:0]                  mem_wdata,
  input  logic                               rd_req,
  output logic                               rd_valid,
  output logic [CYC_W+PC_W+2+2*DATA_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]             count,
  output logic                               triggered,
  output logic                               done,
  output logic                               halt
);

  localparam int unsigned ENT_W  = CYC_W + PC_W + 2 + 2 * DATA_W;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT) + 1;
  localparam int unsigned POST_W = $clog2(POST + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t              r_state, w_state_nxt;
  logic [CYC_W-1:0]    r_cyc;
  logic [TMO_W-1:0]    r_tmo;
  logic [POST_W-1:0]   r_post, w_post_nxt;
  logic                r_trig, w_trig_set;
  logic                w_mem_we;
  logic [DATA_W-1:0]   w_mem_addr, w_mem_wdata;
  logic [1:0]          w_kind;
  logic [DATA_W-1:0]   w_addr, w_data;
  logic                w_capturing, w_wr, w_rd, w_tmo_hit, w_full;
  logic [ENT_W-1:0]    w_entry;

`ifdef CPU_TRACE_MEMWR_EN
  assign w_mem_we    = mem_we;
  assign w_mem_addr  = mem_addr;
  assign w_mem_wdata = mem_wdata;
`else
  logic w_unused_mem;
  assign w_unused_mem = ^{mem_we, mem_addr, mem_wdata};
  assign w_mem_we    = 1'b0;
  assign w_mem_addr  = '0;
  assign w_mem_wdata = '0;
`endif

  // Simultaneous writes keep the memory address/data; the register data is dropped.
  always_comb begin
    w_kind = '0;
    w_addr = '0;
    w_data = '0;
    if (w_mem_we) begin
      w_kind = reg_we ? KIND_BOTH : KIND_MEM;
      w_addr = w_mem_addr;
      w_data = w_mem_wdata;
    end else if (reg_we) begin
      w_kind = KIND_REG;
      w_addr = {{(DATA_W-REG_W){1'b0}}, reg_addr};
      w_data = reg_wdata;
    end
  end

  assign w_capturing = arm || (r_state == S_ARMED) || (r_state == S_POSTCAP);
  assign w_wr        = w_capturing && (reg_we || w_mem_we);
  assign w_rd        = rd_req && (r_state == S_DONE) && !arm;
  assign w_tmo_hit   = (r_tmo == TMO_LAST);
  // The arm-cycle event is stamped 0; r_cyc already holds the next stamp afterwards.
  assign w_entry     = {(arm ? CYC_W'(0) : r_cyc), pc, w_kind, w_addr, w_data};

  always_comb begin
    w_state_nxt = r_state;
    w_post_nxt  = r_post;
    w_trig_set  = 1'b0;
    if (arm) begin
      w_state_nxt = S_ARMED;
      w_post_nxt  = '0;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (pc == trig_pc) begin
            w_trig_set  = 1'b1;
            w_post_nxt  = w_wr ? POST_W'(1) : '0;
            w_state_nxt = (w_wr && POST == 1) ? S_DONE : S_POSTCAP;
          end
          if (w_tmo_hit) w_state_nxt = S_DONE;
        end
        S_POSTCAP: begin
          if (w_wr) w_post_nxt = r_post + 1'b1;
          if ((w_wr && r_post == POST_W'(POST - 1)) || w_tmo_hit) w_state_nxt = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_tmo   <= '0;
      r_post  <= '0;
      r_trig  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_post  <= w_post_nxt;
      if (arm) begin
        r_cyc  <= CYC_W'(1);
        r_tmo  <= '0;
        r_trig <= 1'b0;
      end else begin
        if (r_state == S_ARMED || r_state == S_POSTCAP) begin
          r_cyc <= r_cyc + 1'b1;
          r_tmo <= r_tmo + 1'b1;
        end
        if (w_trig_set) r_trig <= 1'b1;
      end
    end
  end

  trace_ring_buf #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_buf (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clr      (arm),
    .i_wr       (w_wr),
    .i_wdata    (w_entry),
    .i_rd       (w_rd),
    .o_rd_valid (rd_valid),
    .o_rd_data  (rd_data),
    .o_count    (count),
    .o_full     (w_full)
  );

  assign triggered = r_trig;
  assign done      = (r_state == S_DONE);
  assign halt      = (r_state == S_DONE);

endmodule
